// File: rtl/fft_stage_sequencer_if.sv
// Bus bundle between the FFT stage sequencer and its controller / datapath.
// The slave side is the sequencer; the master side requests transforms and consumes addresses.
interface fft_stage_sequencer_if #(
   parameter int LOG2N = 8
);
   logic             start;
   logic             hold;
   logic             busy;
   logic             done;
   logic [3:0]       stage;
   logic             rd_en;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [LOG2N-2:0] tw_addr;
   logic             wr_en;
   logic [LOG2N-1:0] wr_addr_a;
   logic [LOG2N-1:0] wr_addr_b;

   modport master (
      output start, hold,
      input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
      input  wr_en, wr_addr_a, wr_addr_b
   );

   modport slave (
      input  start, hold,
      output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
      output wr_en, wr_addr_a, wr_addr_b
   );
endinterface

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT scheduler: one butterfly per cycle per stage, with a
// write-back delay line matching the free-running datapath and a drain between stages.
module fft_stage_sequencer #(
   parameter int LOG2N   = 8,
   parameter int ROM_LAT = 1,
   parameter int MUL_LAT = 6,
   parameter int ADD_LAT = 8
) (
   input logic                  clk,
   input logic                  rst,
   fft_stage_sequencer_if.slave bus
);
   localparam int               PIPE_LAT   = ROM_LAT + MUL_LAT + ADD_LAT;
   localparam int               HALF_N     = 1 << (LOG2N - 1);
   localparam logic [LOG2N-2:0] K_LAST     = (LOG2N-1)'(HALF_N - 1);
   localparam logic [LOG2N-2:0] K_ONE      = 1;
   localparam logic [LOG2N-1:0] A_ONE      = 1;
   localparam logic [3:0]       LAST_STAGE = 4'(LOG2N - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [3:0]       stage_q, stage_d;
   logic [LOG2N-2:0] k_q, k_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             rd_en_q, rd_en_d;
   logic [LOG2N-1:0] rd_a_q, rd_a_d;
   logic [LOG2N-1:0] rd_b_q, rd_b_d;
   logic [LOG2N-2:0] tw_q, tw_d;

   logic             pipe_v_q [PIPE_LAT];
   logic             pipe_v_d [PIPE_LAT];
   logic [LOG2N-1:0] pipe_a_q [PIPE_LAT];
   logic [LOG2N-1:0] pipe_a_d [PIPE_LAT];
   logic [LOG2N-1:0] pipe_b_q [PIPE_LAT];
   logic [LOG2N-1:0] pipe_b_d [PIPE_LAT];

   logic             issue;
   logic [3:0]       iss_stage;
   logic [LOG2N-2:0] iss_k;
   logic             in_flight;

   // The entry leaving the delay line this cycle is written at the next edge, so the
   // next stage may issue alongside it without a read-after-write hazard.
   always_comb begin
      in_flight = rd_en_q;
      for (int i = 0; i < PIPE_LAT - 1; i++) begin
         in_flight = in_flight | pipe_v_q[i];
      end
   end

   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      k_d       = k_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      issue     = 1'b0;
      iss_stage = stage_q;
      iss_k     = k_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               issue     = 1'b1;
               iss_stage = 4'd0;
               iss_k     = '0;
               stage_d   = 4'd0;
               k_d       = K_ONE;
               busy_d    = 1'b1;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (!bus.hold) begin
               issue = 1'b1;
               if (k_q == K_LAST) begin
                  k_d     = '0;
                  state_d = DRAIN;
               end else begin
                  k_d = k_q + K_ONE;
               end
            end
         end
         DRAIN: begin
            if (!in_flight) begin
               if (stage_q == LAST_STAGE) begin
                  stage_d = 4'd0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  issue     = 1'b1;
                  iss_stage = stage_q + 4'd1;
                  iss_k     = '0;
                  stage_d   = stage_q + 4'd1;
                  k_d       = K_ONE;
                  state_d   = ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Butterfly k of stage s pairs a and a+2^s, where a inserts a zero at bit s of k.
   logic [LOG2N-1:0] kx, half, mask, addr_a;
   always_comb begin
      kx     = {1'b0, iss_k};
      half   = A_ONE << iss_stage;
      mask   = half - A_ONE;
      addr_a = ((kx >> iss_stage) << (iss_stage + 4'd1)) | (kx & mask);
      rd_en_d = issue;
      rd_a_d  = issue ? addr_a : '0;
      rd_b_d  = issue ? (addr_a | half) : '0;
      tw_d    = issue ? ((iss_k & mask[LOG2N-2:0]) << (LAST_STAGE - iss_stage)) : '0;
   end

   always_comb begin
      for (int i = 0; i < PIPE_LAT; i++) begin
         if (i == 0) begin
            pipe_v_d[i] = rd_en_q;
            pipe_a_d[i] = rd_a_q;
            pipe_b_d[i] = rd_b_q;
         end else begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_a_d[i] = pipe_a_q[i-1];
            pipe_b_d[i] = pipe_b_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         stage_q <= 4'd0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
         rd_a_q  <= '0;
         rd_b_q  <= '0;
         tw_q    <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            pipe_v_q[i] <= 1'b0;
            pipe_a_q[i] <= '0;
            pipe_b_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rd_en_q <= rd_en_d;
         rd_a_q  <= rd_a_d;
         rd_b_q  <= rd_b_d;
         tw_q    <= tw_d;
         for (int i = 0; i < PIPE_LAT; i++) begin
            pipe_v_q[i] <= pipe_v_d[i];
            pipe_a_q[i] <= pipe_a_d[i];
            pipe_b_q[i] <= pipe_b_d[i];
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.stage     = stage_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr_a = rd_a_q;
   assign bus.rd_addr_b = rd_b_q;
   assign bus.tw_addr   = tw_q;
   assign bus.wr_en     = pipe_v_q[PIPE_LAT-1];
   assign bus.wr_addr_a = pipe_a_q[PIPE_LAT-1];
   assign bus.wr_addr_b = pipe_b_q[PIPE_LAT-1];
endmodule
